// File: rtl/ps2_mouse_init_seq.sv
// PS/2 mouse bring-up sequencer: reset, BAT/ID check, set sample rate, enable
// reporting. Drives the transmitter handshake and interprets the mouse's replies.
module ps2_mouse_init_seq #(
  parameter int unsigned POWERUP_DELAY = 25000000,
  parameter int unsigned TX_TIMEOUT    = 1000000,
  parameter int unsigned ACK_TIMEOUT   = 1250000,
  parameter int unsigned BAT_TIMEOUT   = 50000000,
  parameter logic [7:0]  SAMPLE_RATE   = 8'd100,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       TxWrite,
  output logic [7:0] TxData,
  input  logic       TxDone,
  input  logic       TxIdle,
  input  logic       RxValid,
  input  logic [7:0] RxData,
  output logic       InitDone,
  output logic       InitError,
  output logic       Busy,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_PWRUP    = 4'd0,
    S_SEND     = 4'd1,
    S_WAIT_TX  = 4'd2,
    S_WAIT_ACK = 4'd3,
    S_WAIT_BAT = 4'd4,
    S_WAIT_ID  = 4'd5,
    S_FAIL     = 4'd6,
    S_DONE     = 4'd7,
    S_ERROR    = 4'd8
  } state_t;

  localparam logic [25:0] T_PWRUP = 26'(POWERUP_DELAY);
  localparam logic [25:0] T_TX    = 26'(TX_TIMEOUT);
  localparam logic [25:0] T_ACK   = 26'(ACK_TIMEOUT);
  localparam logic [25:0] T_BAT   = 26'(BAT_TIMEOUT);

  state_t      state;
  logic [1:0]  step;
  logic [7:0]  retry_cnt;
  logic [25:0] timer;
  logic [7:0]  retry_inc;
  logic        retry_exhausted;
  logic        timeout;

  function automatic logic [7:0] cmd_for(input logic [1:0] s);
    case (s)
      2'd0:    cmd_for = 8'hFF;
      2'd1:    cmd_for = 8'hF3;
      2'd2:    cmd_for = SAMPLE_RATE;
      default: cmd_for = 8'hF4;
    endcase
  endfunction

  assign retry_inc       = retry_cnt + 8'd1;
  assign retry_exhausted = {24'd0, retry_inc} >= MAX_RETRY;
  assign timeout         = (timer == 26'd0);
  assign State           = state;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_PWRUP;
      step      <= 2'd0;
      retry_cnt <= 8'd0;
      timer     <= T_PWRUP;
      TxWrite   <= 1'b0;
      TxData    <= 8'h00;
      InitDone  <= 1'b0;
      InitError <= 1'b0;
      Busy      <= 1'b1;
    end else begin
      TxWrite <= 1'b0;
      case (state)
        S_PWRUP:
          if (timeout) state <= S_SEND;
          else         timer <= timer - 26'd1;
        S_SEND:
          if (TxIdle) begin
            TxData  <= cmd_for(step);
            TxWrite <= 1'b1;
            timer   <= T_TX;
            state   <= S_WAIT_TX;
          end
        S_WAIT_TX:
          if (TxDone) begin
            timer <= T_ACK;
            state <= S_WAIT_ACK;
          end else if (timeout) state <= S_FAIL;
          else                  timer <= timer - 26'd1;
        // A received byte always wins over a timeout in the same cycle.
        S_WAIT_ACK:
          if (RxValid) begin
            if (RxData == 8'hFA) begin
              if (step == 2'd0) begin
                timer <= T_BAT;
                state <= S_WAIT_BAT;
              end else if (step == 2'd3) begin
                InitDone <= 1'b1;
                Busy     <= 1'b0;
                state    <= S_DONE;
              end else begin
                step  <= step + 2'd1;
                state <= S_SEND;
              end
            end else if (RxData == 8'hFE) begin
              retry_cnt <= retry_inc;
              if (retry_exhausted) begin
                InitError <= 1'b1;
                Busy      <= 1'b0;
                state     <= S_ERROR;
              end else state <= S_SEND;
            end else state <= S_FAIL;
          end else if (timeout) state <= S_FAIL;
          else                  timer <= timer - 26'd1;
        S_WAIT_BAT:
          if (RxValid) begin
            if (RxData == 8'hAA) begin
              timer <= T_BAT;
              state <= S_WAIT_ID;
            end else state <= S_FAIL;
          end else if (timeout) state <= S_FAIL;
          else                  timer <= timer - 26'd1;
        S_WAIT_ID:
          if (RxValid) begin
            if (RxData == 8'h00) begin
              step  <= 2'd1;
              state <= S_SEND;
            end else state <= S_FAIL;
          end else if (timeout) state <= S_FAIL;
          else                  timer <= timer - 26'd1;
        S_FAIL: begin
          retry_cnt <= retry_inc;
          if (retry_exhausted) begin
            InitError <= 1'b1;
            Busy      <= 1'b0;
            state     <= S_ERROR;
          end else begin
            step  <= 2'd0;
            state <= S_SEND;
          end
        end
        // A restart skips the power-up delay and begins again at the reset command.
        S_DONE, S_ERROR:
          if (Start) begin
            InitDone  <= 1'b0;
            InitError <= 1'b0;
            retry_cnt <= 8'd0;
            step      <= 2'd0;
            Busy      <= 1'b1;
            state     <= S_SEND;
          end
        default: begin
          timer <= T_PWRUP;
          state <= S_PWRUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_init_seq.sv
// Bench for ps2_mouse_init_seq: a scripted mouse/transmitter responder, a
// transaction-level outcome model, table vectors and randomized scenarios.
module tb_ps2_mouse_init_seq;
  localparam int PWR   = 10;
  localparam int TXT   = 30;
  localparam int ACKT  = 20;
  localparam int BATT  = 40;
  localparam int MAXR  = 3;
  localparam logic [7:0] SR = 8'd100;
  localparam int LIMIT = 4000;

  logic       Clk = 1'b0;
  logic       Reset, Start, TxWrite, TxDone, TxIdle, RxValid;
  logic       InitDone, InitError, Busy;
  logic [7:0] TxData, RxData;
  logic [3:0] State;

  ps2_mouse_init_seq #(
    .POWERUP_DELAY(PWR), .TX_TIMEOUT(TXT), .ACK_TIMEOUT(ACKT),
    .BAT_TIMEOUT(BATT), .SAMPLE_RATE(SR), .MAX_RETRY(MAXR)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .TxWrite(TxWrite), .TxData(TxData),
    .TxDone(TxDone), .TxIdle(TxIdle), .RxValid(RxValid), .RxData(RxData),
    .InitDone(InitDone), .InitError(InitError), .Busy(Busy), .State(State)
  );

  always #5 Clk = ~Clk;

  // Reactions of the mouse to one transmitted command.
  localparam int R_ACK = 0, R_RESEND = 1, R_BAD = 2, R_NOACK = 3,
                 R_NOTXDONE = 4, R_BATBAD = 5, R_IDBAD = 6;

  typedef struct {
    logic [31:0] react;  // reaction nibbles, first command in the most significant used nibble
    int          nr;
    logic [95:0] bytes;  // expected TxData sequence, first byte most significant
    int          nb;
    bit          done;
  } vec_t;

  int checks = 0, errors = 0, cyc = 0;
  int rq[$];
  logic [7:0] sent_q[$], eq[$];
  bit exp_done, stray_en;
  int first_wr, noack_mark, noack_gap;
  int viol = 0;
  logic prev_wr = 1'b0, idle_q = 1'b1;

  always @(posedge Clk) idle_q <= TxIdle;
  always @(negedge Clk) begin
    if (Reset !== 1'b1) prev_wr = 1'b0;
    else begin
      if (TxWrite === 1'b1 && (!idle_q || prev_wr)) viol++;
      prev_wr = TxWrite;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    cyc++;
  endtask

  task automatic send_rx(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) tick();
    RxData = b; RxValid = 1'b1;
    tick();
    RxValid = 1'b0;
  endtask

  // Outcome model: walks the command list using the mouse reactions.
  task automatic model_run();
    logic [7:0] cmds [4];
    int step = 0, retry = 0, i = 0, r;
    cmds[0] = 8'hFF; cmds[1] = 8'hF3; cmds[2] = SR; cmds[3] = 8'hF4;
    eq.delete(); exp_done = 1'b0;
    while (1) begin
      eq.push_back(cmds[step]);
      r = (i < rq.size()) ? rq[i] : R_ACK;
      i++;
      if (step != 0 && r >= R_BATBAD) r = R_BAD;
      if (r == R_ACK) begin
        if (step == 3) begin exp_done = 1'b1; break; end
        step++;
      end else begin
        retry++;
        if (retry >= MAXR) break;
        if (r != R_RESEND) step = 0;
      end
    end
  endtask

  task automatic run_scenario();
    int start_cyc, r, ri;
    logic [7:0] cmd;
    start_cyc = cyc; ri = 0;
    sent_q.delete(); first_wr = -1; noack_mark = -1; noack_gap = -1;
    while (Busy === 1'b1 && cyc - start_cyc < LIMIT) begin
      tick();
      if (TxWrite === 1'b1) begin
        cmd = TxData;
        sent_q.push_back(cmd);
        if (first_wr < 0) first_wr = cyc - start_cyc;
        if (noack_mark >= 0 && noack_gap < 0) noack_gap = cyc - noack_mark;
        TxIdle = 1'b0;
        r = (ri < rq.size()) ? rq[ri] : R_ACK;
        ri++;
        if (cmd != 8'hFF && r >= R_BATBAD) r = R_BAD;
        if (r == R_NOTXDONE) begin
          repeat (TXT + 4) tick();
          TxIdle = 1'b1;
        end else begin
          if (stray_en) begin
            RxData = 8'hFA; RxValid = 1'b1; tick(); RxValid = 1'b0;
          end
          repeat ($urandom_range(1, 4)) tick();
          TxDone = 1'b1;
          if (r == R_NOACK && noack_mark < 0) noack_mark = cyc;
          tick();
          TxDone = 1'b0; TxIdle = 1'b1;
          case (r)
            R_ACK: begin
              send_rx(8'hFA);
              if (cmd == 8'hFF) begin send_rx(8'hAA); send_rx(8'h00); end
            end
            R_RESEND: send_rx(8'hFE);
            R_BAD:    send_rx(8'h12);
            R_BATBAD: begin send_rx(8'hFA); send_rx(8'hFC); end
            R_IDBAD:  begin send_rx(8'hFA); send_rx(8'hAA); send_rx(8'h05); end
            default: ;
          endcase
        end
      end
    end
    chk("scenario_finished_busy", Busy, 1'b0);
  endtask

  task automatic check_outcome(input string nm);
    int n;
    chk({nm, "_nwrites"}, sent_q.size(), eq.size());
    for (int i = 0; i < eq.size() && i < sent_q.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), sent_q[i], eq[i]);
    chk({nm, "_InitDone"}, InitDone, exp_done);
    chk({nm, "_InitError"}, InitError, !exp_done);
    chk({nm, "_State"}, State, exp_done ? 7 : 8);
    n = 0;
    repeat (30) begin tick(); if (TxWrite === 1'b1) n++; end
    chk({nm, "_no_write_after_end"}, n, 0);
  endtask

  task automatic start_pulse(input string nm);
    Start = 1'b1; tick(); Start = 1'b0;
    chk({nm, "_start_InitDone"}, InitDone, 1'b0);
    chk({nm, "_start_InitError"}, InitError, 1'b0);
    chk({nm, "_start_Busy"}, Busy, 1'b1);
    chk({nm, "_start_State"}, State, 4'd1);
  endtask

  task automatic load_vec(input vec_t v);
    rq.delete(); eq.delete();
    for (int i = 0; i < v.nr; i++) rq.push_back(int'(v.react[4*(v.nr-1-i) +: 4]));
    for (int i = 0; i < v.nb; i++) eq.push_back(v.bytes[8*(v.nb-1-i) +: 8]);
    exp_done = v.done;
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "_State"}, State, 4'd0);
    chk({nm, "_Busy"}, Busy, 1'b1);
    chk({nm, "_TxWrite"}, TxWrite, 1'b0);
    chk({nm, "_TxData"}, TxData, 8'h00);
    chk({nm, "_InitDone"}, InitDone, 1'b0);
    chk({nm, "_InitError"}, InitError, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int n, k;
    vt[0] = '{react: 32'h0,     nr: 0, bytes: 96'hFF_F3_64_F4,             nb: 4, done: 1'b1};
    vt[1] = '{react: 32'h01000, nr: 5, bytes: 96'hFF_F3_F3_64_F4,          nb: 5, done: 1'b1};
    vt[2] = '{react: 32'h555,   nr: 3, bytes: 96'hFF_FF_FF,                nb: 3, done: 1'b0};
    vt[3] = '{react: 32'h0003,  nr: 4, bytes: 96'hFF_F3_64_F4_FF_F3_64_F4, nb: 8, done: 1'b1};
    vt[4] = '{react: 32'h4,     nr: 1, bytes: 96'hFF_FF_F3_64_F4,          nb: 5, done: 1'b1};
    vt[5] = '{react: 32'h602,   nr: 3, bytes: 96'hFF_FF_F3_FF_F3_64_F4,    nb: 7, done: 1'b1};
    vt[6] = '{react: 32'h0111,  nr: 4, bytes: 96'hFF_F3_F3_F3,             nb: 4, done: 1'b0};
    vt[7] = '{react: 32'h0122,  nr: 4, bytes: 96'hFF_F3_F3_FF,             nb: 4, done: 1'b0};

    Reset = 1'b0; Start = 1'b0; TxDone = 1'b0; TxIdle = 1'b1;
    RxValid = 1'b0; RxData = 8'h00; stray_en = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");

    // Power-up: the timer reads 10..0 over 11 cycles, then SEND issues the write.
    Reset = 1'b1;
    load_vec(vt[0]);
    run_scenario();
    chk("first_write_latency", first_wr - 1, PWR + 1);
    check_outcome("happy");

    for (int v = 1; v < 8; v++) begin
      load_vec(vt[v]);
      start_pulse($sformatf("vec%0d", v));
      run_scenario();
      check_outcome($sformatf("vec%0d", v));
      // 21 cycles in WAIT_ACK, one in FAIL, one in SEND before the write shows.
      if (v == 3) chk("ack_timeout_gap", noack_gap, ACKT + 4);
    end

    // TxIdle held low in SEND, with an ignored Start while busy.
    TxIdle = 1'b0;
    start_pulse("hold");
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (TxWrite === 1'b1) n++;
      if (i == 25) Start = 1'b1;
      if (i == 26) Start = 1'b0;
    end
    chk("hold_no_write", n, 0);
    chk("hold_state", State, 4'd1);
    TxIdle = 1'b1; stray_en = 1'b1;
    load_vec(vt[0]);
    run_scenario();
    check_outcome("hold_stray");

    // Asynchronous reset while waiting for BAT.
    stray_en = 1'b0;
    start_pulse("rst");
    k = 0;
    while (TxWrite !== 1'b1 && k < 20) begin tick(); k++; end
    chk("rst_first_cmd", TxData, 8'hFF);
    TxIdle = 1'b0; tick();
    TxDone = 1'b1; tick(); TxDone = 1'b0; TxIdle = 1'b1;
    RxData = 8'hFA; RxValid = 1'b1; tick(); RxValid = 1'b0;
    chk("rst_in_wait_bat", State, 4'd4);
    #2 Reset = 1'b0;
    #1 check_reset_values("async_reset");
    tick(); tick();
    Reset = 1'b1;
    load_vec(vt[0]);
    run_scenario();
    chk("rst_first_write_latency", first_wr - 1, PWR + 1);
    check_outcome("after_reset");

    // Randomized scenarios against the outcome model.
    for (int s = 0; s < 16; s++) begin
      rq.delete();
      repeat ($urandom_range(0, 6)) rq.push_back(int'($urandom_range(0, 6)));
      stray_en = $urandom_range(0, 1) != 0;
      model_run();
      start_pulse($sformatf("rand%0d", s));
      run_scenario();
      check_outcome($sformatf("rand%0d", s));
    end

    chk("write_handshake_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
